// File: rtl/multdiv_issue_pkg.sv
// rtl/multdiv_issue_pkg.sv - shared types and constants for the mult/div issue controller
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;
  localparam int unsigned RSTATUS_REG_DEFAULT = 30;

endpackage

// File: rtl/md_timeout_ctr.sv
// rtl/md_timeout_ctr.sv - saturating 7-bit cycle counter with clear and enable
module md_timeout_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [6:0] count_o
);

  logic [6:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 7'd0;
    end else if (en_i && (count_q != 7'h7f)) begin
      count_d = count_q + 7'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multdiv_issue.sv
// rtl/multdiv_issue.sv - issues one mult/div op, stalls the front end, returns a writeback
// Optional WAIT abort via macro MULTDIV_TIMEOUT_EN.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned RSTATUS_REG    = RSTATUS_REG_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [31:0] dx_operandA,
  input  logic [31:0] dx_operandB,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 127)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..127");
  end

  md_state_e   state_q, state_d;
  logic        is_div_q;
  logic [31:0] opa_q, opb_q, result_q;
  logic [4:0]  rd_q;
  logic        exc_q;
  logic        accept;
  logic        timeout;

  assign accept = dx_valid & (dx_is_mult | dx_is_div);

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] wait_count;

  // Cleared during START so the first WAIT cycle sees zero.
  md_timeout_ctr u_timeout_ctr (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (state_q == S_START),
    .en_i    (state_q == S_WAIT),
    .count_o (wait_count)
  );

  assign timeout = (state_q == S_WAIT) && (wait_count == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (md_resultRDY || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Mult wins when both op flags are set; a timeout reads as an exception.
  always_ff @(posedge clock) begin
    if (reset) begin
      is_div_q <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && accept) begin
        is_div_q <= ~dx_is_mult;
        opa_q    <= dx_operandA;
        opb_q    <= dx_operandB;
        rd_q     <= dx_rd;
      end
      if (state_q == S_WAIT) begin
        if (md_resultRDY) begin
          result_q <= md_result;
          exc_q    <= md_exception;
        end else if (timeout) begin
          result_q <= 32'd0;
          exc_q    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    stall        = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  stall = accept;
      S_START: begin
        stall        = 1'b1;
        md_ctrl_MULT = ~is_div_q;
        md_ctrl_DIV  = is_div_q;
      end
      S_WAIT:  stall = 1'b1;
      S_DONE: begin
        if (exc_q) begin
          wb_valid = 1'b1;
          wb_rd    = RSTATUS_RD;
          wb_data  = is_div_q ? EXC_DIV : EXC_MULT;
        end else if (rd_q != 5'd0) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = result_q;
        end
      end
      default: ;
    endcase
  end

  assign md_operandA = opa_q;
  assign md_operandB = opb_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// tb/tb_multdiv_issue.sv - self-checking bench for multdiv_issue against a transaction-level model
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_valid, dx_is_mult, dx_is_div;
  logic [31:0] dx_operandA, dx_operandB;
  logic [4:0]  dx_rd;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic        stall, wb_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multdiv_issue #(.TIMEOUT_CYCLES(64), .RSTATUS_REG(30)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_valid     (dx_valid),
    .dx_is_mult   (dx_is_mult),
    .dx_is_div    (dx_is_div),
    .dx_operandA  (dx_operandA),
    .dx_operandB  (dx_operandB),
    .dx_rd        (dx_rd),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One op: accept cycle is cycle 1, START cycle 2, n WAIT cycles, DONE at cycle n+3.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int n, input logic [31:0] res,
                        input bit exc, input bit rdy_en);
    bit          exp_div, exp_exc, exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int mp = 0, dp = 0, wb_cnt = 0, wb_cyc = 0;
    exp_div = d && !m;
    exp_exc = rdy_en ? exc : 1'b1;
    exp_valid = exp_exc || (rd != 5'd0);
    exp_rd    = exp_exc ? 5'd30 : rd;
    exp_data  = exp_exc ? (exp_div ? 32'd5 : 32'd4) : res;

    dx_valid = 1'b1; dx_is_mult = m; dx_is_div = d;
    dx_operandA = a; dx_operandB = b; dx_rd = rd;
    md_resultRDY = 1'b0;
    #1;
    chk("accept_stall", {31'd0, stall}, 32'd1);

    for (int c = 2; c <= n + 3; c++) begin
      next_cycle();
      dx_valid     = (c <= n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      dx_is_mult   = 1'($urandom_range(0, 1));
      dx_is_div    = 1'($urandom_range(0, 1));
      dx_operandA  = $urandom;
      dx_operandB  = $urandom;
      dx_rd        = 5'($urandom);
      md_resultRDY = (rdy_en && (c == n + 2)) || (c == 2);
      md_result    = (c == n + 2) ? res : $urandom;
      md_exception = (c == n + 2) ? exc : 1'($urandom_range(0, 1));
      #1;
      mp += int'(md_ctrl_MULT);
      dp += int'(md_ctrl_DIV);
      chk("operandA_held", md_operandA, a);
      chk("operandB_held", md_operandB, b);
      chk("stall", {31'd0, stall}, {31'd0, (c <= n + 2)});
      if (wb_valid) begin
        wb_cnt++;
        wb_cyc = c;
      end
      if (c == n + 3) begin
        chk("done_wb_valid", {31'd0, wb_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
          chk("wb_data", wb_data, exp_data);
        end
      end
    end
    md_resultRDY = 1'b0;
    chk("mult_pulses", mp, exp_div ? 0 : 1);
    chk("div_pulses", dp, exp_div ? 1 : 0);
    chk("wb_count", wb_cnt, exp_valid ? 1 : 0);
    if (exp_valid) chk("latency", wb_cyc, n + 3);
  endtask

  task automatic idle_check(input string tag);
    next_cycle();
    dx_valid = 1'b0;
    md_resultRDY = 1'b0;
    #1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    bit rm, rdv, rx;
    int rn;
    reset = 1'b1;
    dx_valid = 1'b0; dx_is_mult = 1'b0; dx_is_div = 1'b0;
    dx_operandA = 32'd0; dx_operandB = 32'd0; dx_rd = 5'd0;
    md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("rst_operandA", md_operandA, 32'd0);

    next_cycle();
    run_op(1, 0, 32'd7, 32'd6, 5'd3, 17, 32'd42, 0, 1);
    idle_check("after_mult");
    next_cycle();
    run_op(0, 1, 32'd100, 32'd0, 5'd9, 4, 32'd0, 1, 1);
    idle_check("after_div_exc");
    next_cycle();
    run_op(1, 0, 32'd3, 32'd5, 5'd0, 6, 32'd15, 0, 1);
    idle_check("after_rd0");
    next_cycle();
    run_op(1, 1, 32'd9, 32'd9, 5'd4, 2, 32'd81, 1, 1);
    next_cycle();
    run_op(0, 1, 32'd50, 32'd7, 5'd31, 1, 32'd7, 0, 1);
    idle_check("after_back_to_back");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom_range(0, 1000);
      rm = 1'($urandom_range(0, 1));
      rdv = !rm || 1'($urandom_range(0, 1));
      rx = ($urandom_range(0, 3) == 0);
      rn = $urandom_range(1, 20);
      rr = rm ? ra * rb : ((rb == 0) ? 32'd0 : ra / rb);
      next_cycle();
      run_op(rm, rdv, ra, rb, 5'($urandom), rn, rr, rx, 1);
    end
    idle_check("after_random");

    // Abandon an op in WAIT cycle 5, then offer a stray completion.
    next_cycle();
    dx_valid = 1'b1; dx_is_mult = 1'b1; dx_is_div = 1'b0;
    dx_operandA = 32'd11; dx_operandB = 32'd12; dx_rd = 5'd7;
    for (int c = 2; c <= 7; c++) begin
      next_cycle();
      dx_valid = 1'b0;
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    md_resultRDY = 1'b1; md_result = 32'd132; md_exception = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("midrst_operandA", md_operandA, 32'd0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      md_resultRDY = 1'b1;
      #1;
      chk("stray_rdy_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("stray_rdy_busy", {31'd0, busy}, 32'd0);
    end
    md_resultRDY = 1'b0;

    next_cycle();
`ifdef MULTDIV_TIMEOUT_EN
    run_op(1, 0, 32'd2, 32'd3, 5'd12, 64, 32'd6, 0, 0);
`else
    run_op(1, 0, 32'd2, 32'd3, 5'd12, 100, 32'd6, 0, 1);
`endif
    idle_check("after_long_wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_issue.md
MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the max WAIT cycles before abort (used only with MULTDIV_TIMEOUT_EN).
REQ-002 SHALL have parameter RSTATUS_REG, default 30, giving the exception destination register.
REQ-003 SHALL use one clock and a synchronous, active-high reset: ports clock and reset.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dx_valid, dx_is_mult, dx_is_div  input  1 each  valid instruction in the DX stage, and its op type.
REQ-007 dx_operandA, dx_operandB  input  32 each  source operands.
REQ-008 dx_rd  input  5  destination register.
REQ-009 md_result  input  32; md_exception  input  1; md_resultRDY  input  1  multiplier/divider outputs.
REQ-010 md_operandA, md_operandB  output  32 each  held operands to the multiplier/divider.
REQ-011 md_ctrl_MULT, md_ctrl_DIV  output  1 each  start pulses.
REQ-012 stall  output  1  freezes PC, FD and DX.
REQ-013 wb_valid  output  1; wb_rd  output  5; wb_data  output  32  writeback request.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> START -> WAIT -> DONE -> IDLE.
REQ-016 IDLE: when dx_valid & (dx_is_mult | dx_is_div), SHALL latch operands, dx_rd and op, go to START, and assert stall combinationally in the same cycle.
REQ-017 If dx_is_mult and dx_is_div are both high, SHALL treat the op as mult.
REQ-018 START: SHALL assert exactly one of md_ctrl_MULT/md_ctrl_DIV for exactly one cycle, then go to WAIT.
REQ-019 md_operandA/B SHALL stay equal to the latched values from START until DONE inclusive, since the multiplier/divider samples them every cycle.
REQ-020 md_resultRDY SHALL be ignored in IDLE and START, which rejects stale completions.
REQ-021 WAIT: on md_resultRDY, SHALL capture md_result and md_exception, then go to DONE.
REQ-022 DONE: SHALL drive wb_valid high for one cycle, drop stall in the same cycle, then go to IDLE.
REQ-023 DONE without exception: wb_rd = latched rd and wb_data = captured result.
REQ-024 DONE with exception: wb_rd = RSTATUS_REG; wb_data = 4 for mult, 5 for div.
REQ-025 If latched rd = 0 and there is no exception, wb_valid SHALL stay low; DONE still lasts one cycle.
REQ-026 stall = (IDLE & new op) | START | WAIT.
REQ-027 Latency from op accepted to wb_valid SHALL be N+3 cycles, where N = WAIT cycles.
REQ-028 In IDLE, a new op SHALL NOT be accepted in the same cycle as DONE; back-to-back ops are accepted the cycle after DONE.
REQ-029 Outside their defined states, wb_* and md_ctrl_* SHALL be 0.

Reset
REQ-030 While reset is high at a clock edge, state SHALL go to IDLE and all outputs SHALL be 0 on the next cycle.
REQ-031 Reset mid-operation (START/WAIT/DONE) SHALL abandon the op with no writeback; a pending md_resultRDY SHALL be ignored per REQ-020.

Configuration
REQ-032 Macro MULTDIV_TIMEOUT_EN: when defined, a WAIT cycle counter SHALL abort to DONE with exception after TIMEOUT_CYCLES cycles, writing 4 for mult or 5 for div to RSTATUS_REG. The counter clears on entry to WAIT.
REQ-033 When MULTDIV_TIMEOUT_EN is undefined, WAIT SHALL last indefinitely until md_resultRDY, and no counter logic SHALL be present.

Structure
REQ-034 Package multdiv_issue_pkg SHALL hold the state enum, the EXC_MULT=4 and EXC_DIV=5 constants, and the RSTATUS_REG default.
REQ-035 Sub-module md_timeout_ctr (saturating 7-bit counter with clear and enable) SHALL be instantiated only under MULTDIV_TIMEOUT_EN.

Verification
REQ-036 Mult 7 x 6, rd=3, RDY after 17 WAIT cycles -> ctrl_MULT pulses once; wb_valid with rd=3, data=42; total latency 20 cycles.
REQ-037 Div 100 / 0 with md_exception=1 -> wb_rd=30, wb_data=5, stall drops in the DONE cycle.
REQ-038 Mult with rd=0 and no exception -> wb_valid never asserts; busy returns to 0.
REQ-039 Reset in WAIT cycle 5, then a stray md_resultRDY -> no writeback; FSM stays IDLE.
REQ-040 Operands on dx_* change every cycle during WAIT -> md_operandA/B stay constant.
REQ-041 With MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=64 and no RDY -> at WAIT cycle 64, wb_rd=30 and wb_data=4 (mult).
